page_frame_sender: RTL and testbench
====================================

# page_frame_sender

Downstream stage of the power-spectrum page buffer, in the `rd_clk` domain. It waits for the buffer's `start` request and raises `busy`. It then sweeps the 512-byte read address of the current page, adds a 14-byte header, and streams the 526-byte frame byte-wise to the Ethernet MAC over a valid/ready interface. It absorbs MAC back-pressure with a small prefetch FIFO, so RAM read latency never drops or repeats a byte.

## Interface
- `RD_LAT`, 1: RAM read latency in cycles, from `addrb_l` to `power_out` valid (1 or 2).
- `FIFO_DEPTH`, 4: prefetch FIFO entries, power of two, ≥ `RD_LAT`+2.
- `clk` in 1: clock, same as the buffer's `rd_clk`.
- `rst_n` in 1: synchronous reset, active low.
- `start` in 1: page-ready request from the buffer, level.
- `user_data` in 64: frame tag, sent first, MSB byte first.
- `page_read` in 16: index of the page being read.
- `power_out` in 8: RAM read data.
- `busy` out 1: frame in progress.
- `addrb_l` out 9: RAM read address within the page.
- `tx_data` out 8: frame byte.
- `tx_valid` out 1: `tx_data` valid.
- `tx_sop` out 1: first byte of frame, qualified by `tx_valid`.
- `tx_eop` out 1: last byte of frame, qualified by `tx_valid`.
- `tx_ready` in 1: MAC accepts the byte when `tx_valid` and `tx_ready` are both high.
- `frame_cnt` out 32: count of completed frames.

## Operation
- Reset values: `busy`=0, `addrb_l`=0, `tx_valid`=0, `tx_sop`=0, `tx_eop`=0, `tx_data`=0, `frame_cnt`=0. The FIFO is emptied and the state goes to IDLE.
- **IDLE**
  - If `start`=1, go to HDR next cycle and set `busy`=1.
  - Capture `page_read` and `user_data` into header registers.
- **HDR:** emit 14 bytes, one per accepted handshake:
  - 8 bytes of `user_data`, bits [63:56] first;
  - 2 bytes of captured `page_read`, MSB first;
  - 4 bytes of `frame_cnt`, MSB first.
  - Byte 0 carries `tx_sop`=1.
- **PAY:** emit 512 bytes from the FIFO, in address order 0..511.
  - Reads may issue during HDR, so the FIFO is primed before PAY starts.
  - A read issues only while (FIFO occupancy + reads in flight) < `FIFO_DEPTH`. `addrb_l` then increments.
  - Data is written into the FIFO `RD_LAT` cycles after its address.
  - The last payload byte carries `tx_eop`=1.
- **DONE:** one cycle.
  - `frame_cnt` increments, wrapping 2^32−1 → 0.
  - `busy` is set to 0 and the state goes to IDLE.
- Address rules:
  - `addrb_l` holds 511 for exactly one cycle per frame. The buffer advances its read page on every cycle it sees 511.
  - After address 511 issues, `addrb_l` returns to 0 the next cycle and stays at 0 until the next frame.
  - `addrb_l` never holds a value other than 0 outside an active sweep.
- Back-pressure: while `tx_valid`=1 and `tx_ready`=0, `tx_data`, `tx_sop`, `tx_eop` and `tx_valid` hold stable. Reads stop once the FIFO credit is exhausted.
- `start` is ignored outside IDLE. The buffer drops it about 2 cycles after seeing `busy`.
- If `start` is still high on the DONE→IDLE cycle, do not begin a new frame. A new frame needs `start` sampled in IDLE.

## Timing
- `start` high in IDLE → `busy` high and first address issue on the next edge.
- `tx_valid` first rises `RD_LAT`+2 cycles after the IDLE→HDR edge, at most. With `tx_ready` held 1, the frame is 526 consecutive cycles of `tx_valid`.
- Throughput: 1 byte/cycle with `tx_ready`=1 continuously, with no bubbles at the HDR→PAY boundary.
- `busy` falls 1 cycle after the `tx_eop` byte is accepted. Minimum `busy`-low time is 1 cycle.
- Reset asserted mid-frame:
  - The next cycle shows reset values on all outputs. The partial frame is abandoned with no `tx_eop`.
  - `frame_cnt` does not increment.

## Test plan
- `RD_LAT`=1, RAM model returns `addr[7:0]`, `user_data`=0x0123456789abcdef, `page_read`=3, `tx_ready`=1 → 526 bytes 01 23 45 67 89 ab cd ef 00 03 00 00 00 00 00 01 … ff 00 … ff. `sop` on byte 0, `eop` on byte 525, `frame_cnt`=1.
- Random `tx_ready` (50% duty), `RD_LAT`=2 → payload identical to the previous case. `addrb_l`=511 for exactly one cycle, and the FIFO never overflows.
- Two frames back to back, with the buffer model's `start` re-asserting 3 cycles after `busy` falls → second header carries `frame_cnt`=1 and `page_read`=4. No `start` is missed or double-counted.
- `frame_cnt` forced to 0xFFFFFFFF → header bytes ff ff ff ff, then `frame_cnt`=0 after DONE.
- `rst_n` low at payload byte 200 → next cycle `busy`=0, `tx_valid`=0, `addrb_l`=0. A new `start` yields a complete frame.
- `start` held high continuously → frames separated by at least 1 IDLE cycle with `busy`=0. Each frame is exactly 526 bytes.

Source files
------------

// File: rtl/page_frame_sender.sv
// page_frame_sender: streams a 14-byte header followed by one 512-byte RAM page to a MAC.
// RAM reads are issued against FIFO credit so read latency and MAC back-pressure never drop or repeat a byte.
module page_frame_sender #(
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [63:0] user_data,
    input  logic [15:0] page_read,
    input  logic [7:0]  power_out,
    output logic        busy,
    output logic [8:0]  addrb_l,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        tx_sop,
    output logic        tx_eop,
    input  logic        tx_ready,
    output logic [31:0] frame_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;

    typedef enum logic [1:0] {S_IDLE, S_HDR, S_PAY, S_DONE} state_t;

    state_t          r_state, w_state_next;
    logic            r_busy;
    logic [31:0]     r_frame_cnt;
    logic [63:0]     r_user;
    logic [15:0]     r_page;
    logic [3:0]      r_idx;
    logic [9:0]      r_pcnt;
    logic [7:0]      r_tx_data;
    logic            r_tx_valid, r_tx_sop, r_tx_eop;
    logic            r_sweep;
    logic [8:0]      r_addr, r_next;
    logic [RD_LAT:0] r_vld;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_load_ok, w_accept, w_go, w_hdr_load, w_pop, w_done;
    logic            w_issue, w_fifo_empty, w_fifo_wr;
    logic [CW-1:0]   w_inflight, w_outstanding;
    logic [111:0]    w_hdr_vec;
    logic [3:0]      w_hdr_sel;
    logic [7:0]      w_hdr_byte;

    assign w_load_ok    = !r_tx_valid || tx_ready;
    assign w_accept     = r_tx_valid && tx_ready;
    assign w_fifo_empty = (r_count == '0);
    assign w_fifo_wr    = r_vld[RD_LAT];
    assign w_hdr_vec    = {r_user, r_page, r_frame_cnt};
    assign w_hdr_sel    = 4'd13 - r_idx;
    assign w_hdr_byte   = w_hdr_vec[{w_hdr_sel, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_HDR;
            S_HDR:   if (w_load_ok && r_idx == 4'd13) w_state_next = S_PAY;
            S_PAY:   if (w_accept && r_tx_eop) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_go       = 1'b0;
        w_hdr_load = 1'b0;
        w_pop      = 1'b0;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE:  w_go       = start;
            S_HDR:   w_hdr_load = w_load_ok;
            S_PAY:   w_pop      = w_load_ok && !w_fifo_empty && !r_pcnt[9];
            S_DONE:  w_done     = 1'b1;
            default: ;
        endcase
    end

    // A slot being popped this cycle is free before any new read can land in it.
    always_comb begin
        w_inflight = '0;
        for (int k = 0; k <= RD_LAT; k++) w_inflight = w_inflight + CW'(r_vld[k]);
    end
    assign w_outstanding = r_count + w_inflight - CW'(w_pop);
    assign w_issue       = r_sweep && (w_outstanding < CW'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
            r_user      <= '0;
            r_page      <= '0;
            r_idx       <= '0;
            r_pcnt      <= '0;
        end else begin
            if (r_state == S_IDLE) begin
                r_user <= user_data;
                r_page <= page_read;
            end
            if (w_go)        r_busy <= 1'b1;
            else if (w_done) r_busy <= 1'b0;
            if (w_done) r_frame_cnt <= r_frame_cnt + 32'd1;
            if (r_state != S_HDR) r_idx <= '0;
            else if (w_hdr_load)  r_idx <= r_idx + 4'd1;
            if (r_state != S_PAY) r_pcnt <= '0;
            else if (w_pop)       r_pcnt <= r_pcnt + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_sop   <= 1'b0;
            r_tx_eop   <= 1'b0;
        end else if (w_load_ok) begin
            r_tx_valid <= w_hdr_load | w_pop;
            if (w_hdr_load) begin
                r_tx_data <= w_hdr_byte;
                r_tx_sop  <= (r_idx == 4'd0);
                r_tx_eop  <= 1'b0;
            end else if (w_pop) begin
                r_tx_data <= r_mem[r_rptr];
                r_tx_sop  <= 1'b0;
                r_tx_eop  <= (r_pcnt == 10'd511);
            end
        end
    end

    // A stalled address is simply re-read and ignored; 511 is never stalled since it ends the sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sweep <= 1'b0;
            r_addr  <= '0;
            r_next  <= '0;
            r_vld   <= '0;
        end else begin
            r_vld <= {r_vld[RD_LAT-1:0], w_go | w_issue};
            if (w_go) begin
                r_addr  <= '0;
                r_next  <= 9'd1;
                r_sweep <= 1'b1;
            end else if (w_issue) begin
                r_addr <= r_next;
                r_next <= r_next + 9'd1;
                if (r_next == 9'd511) r_sweep <= 1'b0;
            end else if (!r_sweep) begin
                r_addr <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_fifo_wr) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + CW'(w_fifo_wr) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_fifo_wr) r_mem[r_wptr] <= power_out;
    end

    assign busy      = r_busy;
    assign addrb_l   = r_addr;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign tx_sop    = r_tx_sop;
    assign tx_eop    = r_tx_eop;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_page_frame_sender.sv
// Bench for page_frame_sender: RAM/buffer model, random MAC back-pressure, and a byte scoreboard
// filled from a frame-level reference model.
module tb_page_frame_sender;
    localparam int RD_LAT     = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] user_data = '0;
    logic [15:0] page_read = 16'd3;
    logic [7:0]  power_out;
    logic        busy;
    logic [8:0]  addrb_l;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_sop, tx_eop;
    logic        tx_ready = 1'b1;
    logic [31:0] frame_cnt;

    page_frame_sender #(.RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .user_data(user_data),
        .page_read(page_read), .power_out(power_out), .busy(busy), .addrb_l(addrb_l),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_sop(tx_sop), .tx_eop(tx_eop),
        .tx_ready(tx_ready), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // RAM with RD_LAT cycles from address to data
    logic [7:0] ram_mem [512];
    logic [7:0] ram_pipe [RD_LAT];
    always @(posedge clk) begin
        ram_pipe[0] <= ram_mem[addrb_l];
        for (int k = 1; k < RD_LAT; k++) ram_pipe[k] <= ram_pipe[k-1];
    end
    assign power_out = ram_pipe[RD_LAT-1];

    typedef struct packed { logic sop; logic eop; logic [7:0] data; } exp_t;
    exp_t sb_q[$];

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, mon_bytes = 0, frames_done = 0, busy_rises = 0, cnt511 = 0;
    int frame_cycles = 0, sop_cyc = 0;
    bit rnd_ready = 1'b0;
    logic [31:0] model_fc = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out at cycle %0d", nm, cyc);
    endtask

    function automatic void push_b(input logic [7:0] d, input logic s, input logic e);
        sb_q.push_back(exp_t'({s, e, d}));
    endfunction

    // Reference frame: tag MSB first, page index, completed-frame count, then the page in address order
    function automatic void push_frame(input logic [63:0] ud, input logic [15:0] pg, input logic [31:0] fc);
        for (int i = 0; i < 8; i++) push_b(ud[63-8*i -: 8], i == 0, 1'b0);
        push_b(pg[15:8], 1'b0, 1'b0);
        push_b(pg[7:0], 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push_b(fc[31-8*i -: 8], 1'b0, 1'b0);
        for (int a = 0; a < 512; a++) push_b(ram_mem[a], 1'b0, a == 511);
    endfunction

    initial forever begin
        @(posedge clk);
        #1;
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: scoreboard pops, stall stability, buffer page model
    logic       prev_stall = 1'b0, prev_busy = 1'b0, prev_sop = 1'b0, prev_eop = 1'b0;
    logic [7:0] prev_data = '0;
    initial forever begin
        exp_t e;
        @(negedge clk);
        cyc++;
        if (!rst_n) begin
            mon_bytes  = 0;
            prev_stall = 1'b0;
            prev_busy  = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(tx_valid), 64'(1));
                chk("stall_hold", 64'({tx_sop, tx_eop, tx_data}), 64'({prev_sop, prev_eop, prev_data}));
            end
            if (tx_valid && tx_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL byte: unexpected byte %0h with queue empty", tx_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("byte", 64'({tx_sop, tx_eop, tx_data}), 64'(e));
                end
                if (tx_sop) sop_cyc = cyc;
                mon_bytes++;
                if (tx_eop) begin
                    frame_cycles = cyc - sop_cyc + 1;
                    frames_done++;
                    $display("frame %0d: %0d bytes over %0d cycles", frames_done, mon_bytes, frame_cycles);
                    mon_bytes = 0;
                end
            end
            if (addrb_l == 9'd511) begin
                cnt511++;
                page_read = page_read + 16'd1;
            end
            if (busy && !prev_busy) busy_rises++;
            prev_busy  = busy;
            prev_stall = tx_valid && !tx_ready;
            prev_sop   = tx_sop;
            prev_eop   = tx_eop;
            prev_data  = tx_data;
        end
    end

    task automatic wait_busy(input logic val, input int max, input string nm);
        int n = 0;
        while (busy !== val && n < max) begin
            @(negedge clk);
            n++;
        end
        if (busy !== val) timeout(nm);
    endtask

    // Start handshake as the buffer does it; returns once busy is seen and start is dropped
    task automatic start_frame();
        int n = 0;
        start = 1'b1;
        wait_busy(1'b1, 20, "busy_rise");
        while (!tx_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("first_valid_latency_ok", 64'(n <= RD_LAT + 2), 64'(1));
        if (n < 2) repeat (2 - n) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input int gap, input bit check_len);
        int c511;
        wait_busy(1'b0, 6000, "busy_idle");
        repeat (gap) @(negedge clk);
        c511 = cnt511;
        push_frame(user_data, page_read, model_fc);
        model_fc = model_fc + 32'd1;
        start_frame();
        wait_busy(1'b0, 6000, "busy_fall");
        @(negedge clk);
        #1;
        chk("frame_cnt", 64'(frame_cnt), 64'(model_fc));
        chk("addr511_cycles", 64'(cnt511 - c511), 64'(1));
        chk("queue_drained", 64'(sb_q.size()), 64'(0));
        if (check_len) chk("frame_cycles", 64'(frame_cycles), 64'(526));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, fd0, r0, c0;
        for (int a = 0; a < 512; a++) ram_mem[a] = 8'(a);
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_addr", 64'(addrb_l), 64'(0));
        chk("rst_valid", 64'(tx_valid), 64'(0));
        chk("rst_sop", 64'(tx_sop), 64'(0));
        chk("rst_eop", 64'(tx_eop), 64'(0));
        chk("rst_data", 64'(tx_data), 64'(0));
        chk("rst_frame_cnt", 64'(frame_cnt), 64'(0));
        #1;
        rst_n = 1'b1;

        // directed frame, no back-pressure
        user_data = 64'h0123_4567_89ab_cdef;
        run_frame(2, 1'b1);

        // random back-pressure, same page content, back-to-back with a 3-cycle gap
        rnd_ready = 1'b1;
        user_data = {$urandom, $urandom};
        run_frame(3, 1'b0);
        for (int a = 0; a < 512; a++) ram_mem[a] = 8'($urandom);
        user_data = {$urandom, $urandom};
        run_frame(3, 1'b0);

        // frame counter wrap
        rnd_ready = 1'b0;
        force dut.r_frame_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_frame_cnt;
        @(negedge clk);
        chk("forced_cnt", 64'(frame_cnt), 64'(32'hFFFF_FFFF));
        model_fc = 32'hFFFF_FFFF;
        run_frame(1, 1'b1);

        // reset during payload byte 200
        user_data = {$urandom, $urandom};
        push_frame(user_data, page_read, model_fc);
        start_frame();
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (mon_bytes < 214 && n < 3000);
        if (mon_bytes < 214) timeout("reach_byte_200");
        rst_n = 1'b0;
        sb_q.delete();
        model_fc = '0;
        @(negedge clk);
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_valid", 64'(tx_valid), 64'(0));
        chk("midrst_addr", 64'(addrb_l), 64'(0));
        chk("midrst_eop", 64'(tx_eop), 64'(0));
        chk("midrst_frame_cnt", 64'(frame_cnt), 64'(0));
        rst_n = 1'b1;
        run_frame(2, 1'b1);

        // start held high for three frames
        rnd_ready = 1'b1;
        for (int a = 0; a < 512; a++) ram_mem[a] = 8'($urandom);
        user_data = {$urandom, $urandom};
        wait_busy(1'b0, 6000, "busy_idle_cont");
        @(negedge clk);
        #1;
        fd0 = frames_done;
        r0  = busy_rises;
        c0  = cnt511;
        for (int k = 0; k < 3; k++) push_frame(user_data, page_read + 16'(k), model_fc + 32'(k));
        model_fc = model_fc + 32'd3;
        start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (frames_done < fd0 + 3 && n < 12000);
        start = 1'b0;
        if (frames_done < fd0 + 3) timeout("continuous_frames");
        wait_busy(1'b0, 6000, "busy_fall_cont");
        repeat (4) @(negedge clk);
        #1;
        chk("cont_busy_rises", 64'(busy_rises - r0), 64'(3));
        chk("cont_addr511_cycles", 64'(cnt511 - c0), 64'(3));
        chk("cont_frame_cnt", 64'(frame_cnt), 64'(model_fc));
        chk("cont_queue_drained", 64'(sb_q.size()), 64'(0));
        chk("cont_idle_valid", 64'(tx_valid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
